// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue and frame sequencer feeding an 8-bit UART transmitter
// Buffers producer bytes and issues one start strobe per frame, then holds the line idle between frames.

module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int GAP_CYCLES   = 10417,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   tx_busy,
    output logic [DATA_BITS-1:0]   tx_data,
    output logic                   tx_start,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   timeout_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    // Terminal values: the counter sits at LAST on the edge that completes the interval.
    localparam logic [CW-1:0] BT_LAST  = CW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic                 do_write;
    logic                 do_pop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign wr_ready = !full;
    assign do_write = wr_valid && !full;
    // Pop decision uses the registered level, so a byte written this edge is never popped this edge.
    assign do_pop   = (state == IDLE) && !empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_valid && full;
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        rd_ptr   <= rd_ptr + 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    cnt      <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Transmitter never acknowledged: the popped byte is abandoned.
                        if (cnt == BT_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        cnt   <= '0;
                        state <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
